data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Responder side of the SRAM-like data interface (req/addr_ok/data_ok) that the MEM stage consumes.
//  Word-addressed data RAM with byte-lane writes, configurable response latency, bounded in-order
//  outstanding requests and optional pseudo-random addr_ok stalls. Sits behind the EX-stage request
//  and stands in for the data bus in simulation and FPGA bring-up.
// PARAMETERS
//  ADDR_W     10        word-address bits; RAM holds 2**ADDR_W 32-bit words
//  LATENCY    2         cycles from accept edge to data_ok cycle; legal range 1..15
//  DEPTH      2         max outstanding accepted-but-unanswered requests; legal range 1..4
//  RAND_STALL 0         1: LFSR randomly deasserts addr_ok; 0: never stalls
//  LFSR_SEED  16'hACE1  reset value of the 16-bit stall LFSR; must be nonzero
// PORTS
//  clk      in   1   clock, rising edge
//  resetn   in   1   synchronous reset, active-low
//  req      in   1   request valid
//  wr       in   1   1 = write, 0 = read
//  size     in   2   0 = byte, 1 = half, 2 = word; informational only (see behaviour)
//  addr     in   32  byte address; word index = addr[ADDR_W+1:2]
//  wstrb    in   4   byte-lane write enables, lane i = wdata[8i+7:8i]
//  wdata    in   32  write data
//  addr_ok  out  1   request accepted this cycle when req & addr_ok
//  data_ok  out  1   one-cycle response pulse; responses return strictly in accept order
//  rdata    out  32  read word, valid only while data_ok is high
// BEHAVIOUR
//  - Reset: addr_ok=0, data_ok=0, rdata=0 during the reset cycle. Response FIFO cleared, so every
//    outstanding response is dropped. LFSR loads LFSR_SEED. RAM contents are not reset.
//  - addr_ok is combinational: (count < DEPTH) & ~stall. stall = RAND_STALL & (lfsr[1:0]==2'b00).
//    The LFSR advances every cycle (x^16+x^14+x^13+x^11).
//    Slots freed by a same-cycle pop are not reused that cycle (no bypass).
//  - Accept (req & addr_ok at edge T):
//    - Write: RAM[idx] byte lane i <= wdata lane i for each wstrb[i]=1, committed at edge T.
//      wstrb=0 is a legal no-op write that still gets a response.
//    - Read: full word RAM[idx] captured at edge T, after any earlier-accepted write.
//      size is ignored; the requester extracts bytes/halves using addr[1:0].
//    - Both: push {wr, word, cnt=LATENCY-1} into the response FIFO.
//  - Each cycle, every valid entry with cnt!=0 decrements. The head entry with cnt==0 drives
//    data_ok=1 and rdata=word (reads) or 32'b0 (writes), then pops at that edge.
//    Result: data_ok is high in cycle T+LATENCY after an accept at edge T, unless an older
//    response occupies that cycle; then it slips one cycle per blocking response.
//  - data_ok is never back-pressured; the requester must take the data in that cycle.
//    The responder has no cancel input. Responses owed to requests flushed in the requester
//    (exception/ertn) are still returned, and the requester discards them.
//  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH. count never
//    exceeds DEPTH and never underflows.
//  - Address bits above ADDR_W+1 are ignored (aliasing). Misalignment is not checked here;
//    ALE is raised upstream.
//  - Without data_ok, rdata is 0; a stale value is a bug.
// TESTING
//  T1 reset: hold resetn=0 for 3 cycles with req=1 -> addr_ok=0, data_ok=0, rdata=0 throughout.
//  T2 word write then read, LATENCY=2: wr 0x100=0xDEADBEEF at edge 0, rd 0x100 at edge 1
//     -> data_ok in cycles 2 and 3; rdata=0 in cycle 2, 0xDEADBEEF in cycle 3.
//  T3 byte lanes: word 0x11223344 at 0x200, then wr wstrb=4'b0100 wdata=0x00AA0000
//     -> read 0x202 returns 0x11AA3344.
//  T4 full, DEPTH=2: req held high for 6 cycles -> addr_ok low after 2 accepts and returns high
//     the cycle after the first data_ok; data_ok count equals accept count, in order.
//  T5 reset mid-flight: accept 2 reads, drop resetn before any data_ok -> no data_ok afterwards;
//     earlier-written RAM data still reads back.
//  T6 RAND_STALL=1, 1000 random reads/writes vs a scoreboard -> every accept answered once,
//     in order, with matching data; addr_ok seen both high and low.

Source files
------------

// File: rtl/data_sram_responder.sv
// SRAM-like data responder: word RAM with byte-lane writes, fixed response latency,
// bounded in-order outstanding responses and optional LFSR-driven addr_ok stalls.
module data_sram_responder #(
    parameter int          ADDR_W     = 10,
    parameter int          LATENCY    = 2,
    parameter int          DEPTH      = 2,
    parameter int          RAND_STALL = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]             mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0]       idx;
    logic [15:0]             lfsr;
    logic                    stall;
    logic                    accept;
    logic                    pop;
    logic [DEPTH-1:0]        q_vld;
    logic [DEPTH-1:0][31:0]  q_word;
    logic [DEPTH-1:0][3:0]   q_cnt;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count;
    logic                    unused_bits;

    // size and out-of-range address bits have no effect on the access
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx     = addr[ADDR_W+1:2];
    assign stall   = (RAND_STALL != 0) && (lfsr[1:0] == 2'b00);
    assign addr_ok = resetn && (count < CW'(DEPTH)) && !stall;
    assign accept  = req && addr_ok;
    assign data_ok = resetn && q_vld[head] && (q_cnt[head] == 4'd0);
    assign pop     = data_ok;
    // write responses carry a zero word, so rdata needs no separate wr flag
    assign rdata   = data_ok ? q_word[head] : 32'd0;

    always_ff @(posedge clk) begin
        if (!resetn)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_vld <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (q_vld[i] && q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= nxt(head);
            end
            // tail never equals a popping head here: accept needs a free slot
            if (accept) begin
                q_vld[tail]  <= 1'b1;
                q_word[tail] <= wr ? 32'd0 : mem[idx];
                q_cnt[tail]  <= 4'(LATENCY - 1);
                tail         <= nxt(tail);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed timing cases on a no-stall instance and a
// randomized run on a stalling instance scored against a queue-based response model.
module tb_data_sram_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rstn, a_req, a_wr, a_addr_ok, a_data_ok;
    logic [1:0]  a_size;
    logic [3:0]  a_wstrb;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_rstn, b_req, b_wr, b_addr_ok, b_data_ok;
    logic [1:0]  b_size;
    logic [3:0]  b_wstrb;
    logic [31:0] b_addr, b_wdata, b_rdata;

    data_sram_responder #(.ADDR_W(10), .LATENCY(2), .DEPTH(2), .RAND_STALL(0)) u_a (
        .clk(clk), .resetn(a_rstn), .req(a_req), .wr(a_wr), .size(a_size), .addr(a_addr),
        .wstrb(a_wstrb), .wdata(a_wdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata));

    data_sram_responder #(.ADDR_W(6), .LATENCY(3), .DEPTH(3), .RAND_STALL(1),
                          .LFSR_SEED(16'hACE1)) u_b (
        .clk(clk), .resetn(b_rstn), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr),
        .wstrb(b_wstrb), .wdata(b_wdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata));

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_set(input logic r, input logic w, input logic [31:0] ad,
                         input logic [3:0] st, input logic [31:0] wd);
        a_req = r; a_wr = w; a_addr = ad; a_wstrb = st; a_wdata = wd; a_size = 2'd2;
    endtask

    // one request on instance A with an empty queue: returns response data and latency
    task automatic a_txn(input logic w, input logic [31:0] ad, input logic [3:0] st,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int n;
        n = 0;
        a_set(1'b1, w, ad, st, wd);
        #1;
        while (!a_addr_ok && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("txn_accept", 32'(a_addr_ok), 32'd1);
        @(posedge clk); #1;
        a_set(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        #1;
        lat = 1;
        while (!a_data_ok && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("txn_data_ok", 32'(a_data_ok), 32'd1);
        rd = a_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [5:0]  exp_ao;
        logic [7:0]  exp_do;
        int          n_acc, n_do;
        int          cyc, acc, init, last_due, occ, n_dut_do, cur_idx, due;
        logic        seen_hi, seen_lo, exp_dok;
        logic [31:0] r;

        a_rstn = 1'b0; b_rstn = 1'b0;
        a_set(1'b1, 1'b0, 32'h100, 4'd0, 32'd0);
        b_req = 1'b0; b_wr = 1'b0; b_size = 2'd0; b_addr = '0; b_wstrb = '0; b_wdata = '0;

        // T1: reset with req high
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("rst_addr_ok", 32'(a_addr_ok), 32'd0);
            chk("rst_data_ok", 32'(a_data_ok), 32'd0);
            chk("rst_rdata", a_rdata, 32'd0);
        end
        @(posedge clk); #1;
        a_rstn = 1'b1;

        // T2: write then read back-to-back, LATENCY 2
        a_set(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        #1; chk("t2_wr_addr_ok", 32'(a_addr_ok), 32'd1);
        @(posedge clk); #1;
        a_set(1'b1, 1'b0, 32'h100, 4'h0, 32'd0);
        #1; chk("t2_rd_addr_ok", 32'(a_addr_ok), 32'd1);
        chk("t2_c1_data_ok", 32'(a_data_ok), 32'd0);
        @(posedge clk); #1;
        a_set(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        #1; chk("t2_c2_data_ok", 32'(a_data_ok), 32'd1);
        chk("t2_c2_rdata", a_rdata, 32'd0);
        @(posedge clk); #2;
        chk("t2_c3_data_ok", 32'(a_data_ok), 32'd1);
        chk("t2_c3_rdata", a_rdata, 32'hDEADBEEF);
        @(posedge clk); #2;
        chk("t2_c4_data_ok", 32'(a_data_ok), 32'd0);
        chk("t2_c4_rdata", a_rdata, 32'd0);
        @(posedge clk); #1;

        // T3: byte-lane merge
        a_txn(1'b1, 32'h200, 4'hF, 32'h11223344, rd, lat);
        chk("t3_wr_rdata", rd, 32'd0);
        chk("t3_latency", 32'(lat), 32'd2);
        a_txn(1'b1, 32'h200, 4'b0100, 32'h00AA0000, rd, lat);
        a_txn(1'b0, 32'h202, 4'h0, 32'd0, rd, lat);
        chk("t3_merge", rd, 32'h11AA3344);

        // T4: req held for 6 cycles against DEPTH 2
        exp_ao = 6'b011011;
        exp_do = 8'b01101100;
        n_acc = 0; n_do = 0;
        a_set(1'b1, 1'b0, 32'h200, 4'h0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 6) a_set(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
            #1;
            if (i < 6) chk($sformatf("t4_addr_ok_c%0d", i), 32'(a_addr_ok), 32'(exp_ao[i]));
            chk($sformatf("t4_data_ok_c%0d", i), 32'(a_data_ok), 32'(exp_do[i]));
            if (a_data_ok) begin
                n_do++;
                chk("t4_rdata", a_rdata, 32'h11AA3344);
            end
            if (a_req && a_addr_ok) n_acc++;
            @(posedge clk); #1;
        end
        chk("t4_accepts", 32'(n_acc), 32'd4);
        chk("t4_responses", 32'(n_do), 32'd4);

        // T5: reset with two reads in flight
        a_txn(1'b1, 32'h300, 4'hF, 32'hCAFEF00D, rd, lat);
        a_set(1'b1, 1'b0, 32'h300, 4'h0, 32'd0);
        #1; chk("t5_rd0_addr_ok", 32'(a_addr_ok), 32'd1);
        @(posedge clk); #2;
        chk("t5_rd1_addr_ok", 32'(a_addr_ok), 32'd1);
        @(posedge clk); #1;
        a_set(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        a_rstn = 1'b0;
        #1; chk("t5_rst_data_ok", 32'(a_data_ok), 32'd0);
        chk("t5_rst_rdata", a_rdata, 32'd0);
        @(posedge clk); #1;
        a_rstn = 1'b1;
        n_do = 0;
        for (int i = 0; i < 6; i++) begin
            #1; if (a_data_ok) n_do++;
            @(posedge clk); #1;
        end
        chk("t5_dropped", 32'(n_do), 32'd0);
        a_txn(1'b0, 32'h300, 4'h0, 32'd0, rd, lat);
        chk("t5_ram_kept", rd, 32'hCAFEF00D);
        chk("t5_latency", 32'(lat), 32'd2);
        a_txn(1'b0, 32'hFFFFF300, 4'h0, 32'd0, rd, lat);
        chk("alias_read", rd, 32'hCAFEF00D);

        // T6: random traffic on the stalling instance, LATENCY 3, DEPTH 3
        @(posedge clk); @(posedge clk); #1;
        b_rstn = 1'b1;
        cyc = 0; acc = 0; init = 0; last_due = -1; n_dut_do = 0; cur_idx = 0;
        seen_hi = 1'b0; seen_lo = 1'b0;
        while ((acc < 1016 || exp_q.size() > 0) && cyc < 20000) begin
            if (acc < 1016 && (init < 16 || $urandom_range(0, 3) != 0)) begin
                if (init < 16) begin
                    cur_idx = init; b_wr = 1'b1; b_wstrb = 4'hF;
                end else begin
                    cur_idx = int'($urandom_range(0, 15));
                    b_wr = 1'($urandom_range(0, 1));
                    b_wstrb = 4'($urandom);
                end
                r = $urandom;
                b_addr = (r & 32'hFFFFFF03) | (32'(cur_idx) << 2);
                b_wdata = $urandom;
                b_size = 2'($urandom_range(0, 2));
                b_req = 1'b1;
            end else begin
                b_req = 1'b0;
            end
            #1;
            occ = exp_q.size();
            if (occ >= 3) chk("rnd_full_addr_ok", 32'(b_addr_ok), 32'd0);
            exp_dok = (occ > 0) && (exp_q[0].due == cyc);
            chk("rnd_data_ok", 32'(b_data_ok), 32'(exp_dok));
            if (b_data_ok) n_dut_do++;
            if (exp_dok) begin
                chk("rnd_rdata", b_rdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("rnd_rdata_idle", b_rdata, 32'd0);
            end
            if (b_addr_ok) seen_hi = 1'b1; else seen_lo = 1'b1;
            if (b_req && b_addr_ok) begin
                due = (cyc + 3 > last_due + 1) ? cyc + 3 : last_due + 1;
                last_due = due;
                if (b_wr) begin
                    for (int k = 0; k < 4; k++)
                        if (b_wstrb[k]) model[cur_idx][8*k +: 8] = b_wdata[8*k +: 8];
                    exp_q.push_back('{data: 32'd0, due: due});
                end else begin
                    exp_q.push_back('{data: model[cur_idx], due: due});
                end
                acc++;
                if (init < 16) init++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b_req = 1'b0;
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_resp_count", 32'(n_dut_do), 32'(acc));
        chk("rnd_addr_ok_high_seen", 32'(seen_hi), 32'd1);
        chk("rnd_addr_ok_low_seen", 32'(seen_lo), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
